// File: rtl/pitch_shifter_mc.sv
// pitch_shifter_mc: multichannel delay-line pitch shifter; define PITCH_SHIFTER_MC_XFADE_EN for the dual-head crossfade build
module pitch_shifter_mc #(
  parameter int DATA_W  = 32,
  parameter int CH      = 2,
  parameter int ADDR_W  = 12,
  parameter int XFADE_W = 6
) (
  input  logic                 CLOCK_50,
  input  logic                 reset_n,
  input  logic                 tick,
  input  logic                 enable,
  input  logic [15:0]          pitch_ratio,
  input  logic [CH*DATA_W-1:0] in_data,
  output logic [CH*DATA_W-1:0] out_data,
  output logic                 out_valid,
  output logic                 overrun
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int PW = ADDR_W + 16;
  localparam int IW = DATA_W + 17;
  localparam int MW = IW + 18;
  localparam logic [ADDR_W-1:0] LAST_FILL = ADDR_W'(DEPTH / 2 - 1);
  localparam logic signed [MW-1:0] SMAX = {{(MW - DATA_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}};
  localparam logic signed [MW-1:0] SMIN = ~SMAX;
`ifdef PITCH_SHIFTER_MC_XFADE_EN
  localparam logic [ADDR_W-1:0] HALF = ADDR_W'(DEPTH / 2);
  localparam logic [ADDR_W-1:0] XF = ADDR_W'(1 << XFADE_W);
  localparam logic [ADDR_W-1:0] XF_HI = ADDR_W'(DEPTH - 1 - (1 << XFADE_W));
  localparam int SH = 16 - XFADE_W;
`endif

  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   w_ptr_q;
  logic [PW-1:0]       r_ptr_q;
  logic [1:0]          gap_q;
  logic                overrun_q;
  logic [DATA_W-1:0]   mem_a_q [CH][DEPTH];
  logic                v1_q, z1_q, v2_q, z2_q, out_valid_q;
  logic [15:0]         f1_q;
  logic [DATA_W-1:0]   a0_q [CH];
  logic [DATA_W-1:0]   a1_q [CH];
  logic signed [IW-1:0] ia_q [CH];
  logic [CH*DATA_W-1:0] out_data_q, res;
  logic                acc, wr;
  logic [ADDR_W-1:0]   idx_a, idx_a1;
  logic [15:0]         frac;
`ifdef PITCH_SHIFTER_MC_XFADE_EN
  logic [DATA_W-1:0]   mem_b_q [CH][DEPTH];
  logic [DATA_W-1:0]   b0_q [CH];
  logic [DATA_W-1:0]   b1_q [CH];
  logic signed [IW-1:0] ib_q [CH];
  logic [15:0]         g1_q, g2_q, gain;
  logic [ADDR_W-1:0]   idx_b, idx_b1, dist;
`endif

  function automatic logic signed [IW-1:0] interp(input logic signed [DATA_W-1:0] s0, input logic signed [DATA_W-1:0] s1, input logic [15:0] f);
    logic signed [IW-1:0] d, fe;
    d = IW'(s1) - IW'(s0);
    fe = IW'(f);
    return IW'(s0) + ((d * fe) >>> 16);
  endfunction

  function automatic logic [DATA_W-1:0] sat(input logic signed [MW-1:0] m);
    return DATA_W'(m > SMAX ? SMAX : (m < SMIN ? SMIN : m));
  endfunction

`ifdef PITCH_SHIFTER_MC_XFADE_EN
  function automatic logic signed [MW-1:0] mix(input logic signed [IW-1:0] ia, input logic signed [IW-1:0] ib, input logic [15:0] g);
    logic signed [MW-1:0] ga, gb;
    logic [15:0] gc;
    gc = ~g;
    ga = MW'(g);
    gb = MW'(gc);
    return (MW'(ia) * ga + MW'(ib) * gb) >>> 16;
  endfunction
`endif

  // A tick is accepted only once the previous one has cleared the 3-cycle spacing window
  assign acc = tick && (gap_q == 2'd0);
  assign wr = acc && enable && (state_q != IDLE);
  assign idx_a = r_ptr_q[PW-1:16];
  assign idx_a1 = idx_a + ADDR_W'(1);
  assign frac = r_ptr_q[15:0];
`ifdef PITCH_SHIFTER_MC_XFADE_EN
  assign idx_b = idx_a + HALF;
  assign idx_b1 = idx_b + ADDR_W'(1);
  assign dist = w_ptr_q - idx_a;
  assign gain = (dist < XF) ? 16'(dist) << SH : (dist > XF_HI) ? 16'(ADDR_W'(DEPTH - 1) - dist) << SH : 16'hFFFF;
`endif

  // Sequencer: state, write/read pointers, tick spacing guard and sticky overrun
  always_ff @(posedge CLOCK_50 or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      w_ptr_q <= '0;
      r_ptr_q <= '0;
      gap_q <= '0;
      overrun_q <= 1'b0;
    end else begin
      gap_q <= acc ? 2'd3 : (gap_q != 2'd0 ? gap_q - 2'd1 : 2'd0);
      overrun_q <= overrun_q | (tick && gap_q != 2'd0);
      if (!enable) state_q <= IDLE;
      else if (state_q == IDLE) begin
        state_q <= FILL;
        w_ptr_q <= '0;
        r_ptr_q <= '0;
      end else if (acc) begin
        w_ptr_q <= w_ptr_q + ADDR_W'(1);
        if (state_q == FILL && w_ptr_q == LAST_FILL) state_q <= RUN;
        if (state_q == RUN) r_ptr_q <= r_ptr_q + PW'({pitch_ratio, 8'b0});
      end
    end

  // Delay-line write; contents are never reset
  always_ff @(posedge CLOCK_50)
    for (int c = 0; c < CH; c++)
      if (wr) begin
        mem_a_q[c][w_ptr_q] <= in_data[c*DATA_W +: DATA_W];
`ifdef PITCH_SHIFTER_MC_XFADE_EN
        mem_b_q[c][w_ptr_q] <= in_data[c*DATA_W +: DATA_W];
`endif
      end

  // Stage 1: fetch both taps per head (same-edge write leaves old data visible) plus fraction and gain
  always_ff @(posedge CLOCK_50 or negedge reset_n)
    if (!reset_n) begin
      v1_q <= 1'b0;
      z1_q <= 1'b0;
      f1_q <= '0;
      a0_q <= '{default: '0};
      a1_q <= '{default: '0};
`ifdef PITCH_SHIFTER_MC_XFADE_EN
      b0_q <= '{default: '0};
      b1_q <= '{default: '0};
      g1_q <= '0;
`endif
    end else begin
      v1_q <= wr;
      if (wr) begin
        z1_q <= state_q == FILL;
        f1_q <= frac;
        for (int c = 0; c < CH; c++) begin
          a0_q[c] <= mem_a_q[c][idx_a];
          a1_q[c] <= mem_a_q[c][idx_a1];
`ifdef PITCH_SHIFTER_MC_XFADE_EN
          b0_q[c] <= mem_b_q[c][idx_b];
          b1_q[c] <= mem_b_q[c][idx_b1];
`endif
        end
`ifdef PITCH_SHIFTER_MC_XFADE_EN
        g1_q <= gain;
`endif
      end
    end

  // Stage 2: linear interpolation per head; dropping enable kills the in-flight sample
  always_ff @(posedge CLOCK_50 or negedge reset_n)
    if (!reset_n) begin
      v2_q <= 1'b0;
      z2_q <= 1'b0;
      ia_q <= '{default: '0};
`ifdef PITCH_SHIFTER_MC_XFADE_EN
      ib_q <= '{default: '0};
      g2_q <= '0;
`endif
    end else begin
      v2_q <= v1_q && enable;
      if (v1_q) begin
        z2_q <= z1_q;
        for (int c = 0; c < CH; c++) begin
          ia_q[c] <= interp(a0_q[c], a1_q[c], f1_q);
`ifdef PITCH_SHIFTER_MC_XFADE_EN
          ib_q[c] <= interp(b0_q[c], b1_q[c], f1_q);
`endif
        end
`ifdef PITCH_SHIFTER_MC_XFADE_EN
        g2_q <= g1_q;
`endif
      end
    end

  for (genvar c = 0; c < CH; c++) begin : g_ch
`ifdef PITCH_SHIFTER_MC_XFADE_EN
    assign res[c*DATA_W +: DATA_W] = sat(mix(ia_q[c], ib_q[c], g2_q));
`else
    assign res[c*DATA_W +: DATA_W] = sat(MW'(ia_q[c]));
`endif
  end

  // Output register: pipeline result (zero while filling) or one-cycle bypass in IDLE; holds otherwise
  always_ff @(posedge CLOCK_50 or negedge reset_n)
    if (!reset_n) begin
      out_data_q <= '0;
      out_valid_q <= 1'b0;
    end else if (v2_q && enable) begin
      out_data_q <= z2_q ? '0 : res;
      out_valid_q <= 1'b1;
    end else if (acc && state_q == IDLE) begin
      out_data_q <= in_data;
      out_valid_q <= 1'b1;
    end else out_valid_q <= 1'b0;

  assign out_data = out_data_q;
  assign out_valid = out_valid_q;
  assign overrun = overrun_q;
endmodule

// File: tb/tb_pitch_shifter_mc.sv
// tb_pitch_shifter_mc: scoreboard bench for pitch_shifter_mc at DATA_W=24, CH=2, ADDR_W=8, XFADE_W=4
module tb_pitch_shifter_mc;
  localparam int XW = 4;
  localparam int DEPTH = 256;

  logic        clk = 1'b0, reset_n = 1'b0, tick = 1'b0, enable = 1'b0;
  logic [15:0] ratio = 16'h0100;
  logic [47:0] in_data = '0;
  logic [47:0] out_data;
  logic        out_valid, overrun;
  int          cyc = 0, nvec = 0, nerr = 0;
  logic [47:0] exp_q[$];
  int          cyc_q[$];
  int          mstate = 0, mw = 0;
  longint      mr = 0;
  longint      mem [2][DEPTH];

  pitch_shifter_mc #(.DATA_W(24), .CH(2), .ADDR_W(8), .XFADE_W(XW)) dut (
    .CLOCK_50(clk), .reset_n(reset_n), .tick(tick), .enable(enable), .pitch_ratio(ratio),
    .in_data(in_data), .out_data(out_data), .out_valid(out_valid), .overrun(overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] expv);
    nvec++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic monitor();
    logic [47:0] e;
    int ec;
    forever begin
      @(negedge clk);
      if (reset_n && out_valid) begin
        nvec++;
        assert (exp_q.size() > 0) else begin
          nerr++;
          $error("FAIL spurious_valid: observed out_valid=1 data %h, expected no output", out_data);
        end
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          ec = cyc_q.pop_front();
          check("out_data", out_data, e);
          nvec++;
          assert (cyc == ec) else begin
            nerr++;
            $error("FAIL out_latency: observed cycle %0d expected cycle %0d", cyc, ec);
          end
        end
      end
    end
  endtask

  function automatic longint sx(input logic [23:0] v);
    return longint'($signed(v));
  endfunction

  function automatic longint interp(input longint s0, input longint s1, input longint f);
    return s0 + (((s1 - s0) * f) >>> 16);
  endfunction

  function automatic logic [23:0] run_out(input int ch, input int ia, input longint f);
    longint a, o;
`ifdef PITCH_SHIFTER_MC_XFADE_EN
    longint b, g, dist;
`endif
    a = interp(mem[ch][ia], mem[ch][(ia + 1) % DEPTH], f);
`ifdef PITCH_SHIFTER_MC_XFADE_EN
    b = interp(mem[ch][(ia + 128) % DEPTH], mem[ch][(ia + 129) % DEPTH], f);
    dist = longint'((mw - ia) & (DEPTH - 1));
    g = dist < (1 << XW) ? dist << (16 - XW) : (dist > DEPTH - 1 - (1 << XW) ? (DEPTH - 1 - dist) << (16 - XW) : 65535);
    o = (a * g + b * (65535 - g)) >>> 16;
`else
    o = a;
`endif
    if (o > 8388607) o = 8388607;
    if (o < -8388608) o = -8388608;
    return o[23:0];
  endfunction

  task automatic set_en(input logic v);
    enable = v;
    if (!v) mstate = 0;
    else if (mstate == 0) begin
      mstate = 1;
      mw = 0;
      mr = 0;
    end
    step(2);
  endtask

  task automatic do_tick(input logic [23:0] c0, input logic [23:0] c1, input bit discard = 0, input bit dbl = 0);
    int ia;
    longint f;
    logic [47:0] o;
    in_data = {c1, c0};
    tick = 1'b1;
    if (mstate == 0) begin
      exp_q.push_back({c1, c0});
      cyc_q.push_back(cyc + 1);
    end else begin
      o = '0;
      if (mstate == 2) begin
        ia = int'(mr >> 16) & (DEPTH - 1);
        f = mr & 65535;
        o = {run_out(1, ia, f), run_out(0, ia, f)};
        mr = (mr + (longint'(ratio) << 8)) & 64'hFFFFFF;
      end
      mem[0][mw] = sx(c0);
      mem[1][mw] = sx(c1);
      if (mstate == 1 && mw == DEPTH / 2 - 1) mstate = 2;
      mw = (mw + 1) % DEPTH;
      if (!discard) begin
        exp_q.push_back(o);
        cyc_q.push_back(cyc + 3);
      end
    end
    step(1);
    tick = 1'b0;
    if (discard) begin
      enable = 1'b0;
      mstate = 0;
    end
    if (dbl) begin
      step(1);
      in_data = ~in_data;
      tick = 1'b1;
      step(1);
      tick = 1'b0;
      step(5);
    end else step(7);
  endtask

  initial begin
    fork monitor(); join_none
    step(3);
    check("rst_out_data", out_data, 48'd0);
    check("rst_out_valid", 48'(out_valid), 48'd0);
    check("rst_overrun", 48'(overrun), 48'd0);
    reset_n = 1'b1;
    step(2);
    do_tick(24'h123456, 24'hFEDCBA);
    check("bypass_hold_data", out_data, 48'hFEDCBA123456);
    check("bypass_hold_valid", 48'(out_valid), 48'd0);
    do_tick(24'h7FFFFF, 24'h800000);
    set_en(1'b1);
    repeat (128) do_tick(24'd1000, 24'd1000);
    repeat (136) do_tick(24'd1000, 24'd1000);
`ifdef PITCH_SHIFTER_MC_XFADE_EN
    check("dc_level", out_data, {24'd999, 24'd999});
`else
    check("dc_level", out_data, {24'd1000, 24'd1000});
`endif
    do_tick(24'd1000, 24'd1000, 1'b1);
    step(8);
    ratio = 16'h0200;
    set_en(1'b1);
    for (int k = 0; k < 428; k++) do_tick(24'(k - 150), 24'(400 - 3 * k));
    ratio = 16'h0180;
    for (int k = 428; k < 468; k++) do_tick(24'(k - 150), 24'(400 - 3 * k));
    check("overrun_before", 48'(overrun), 48'd0);
    do_tick(24'd468, 24'd77, 1'b0, 1'b1);
    check("overrun_set", 48'(overrun), 48'd1);
    for (int k = 0; k < 3; k++) do_tick(24'(469 + k), 24'(78 + k));
    check("overrun_held", 48'(overrun), 48'd1);
    in_data = {24'd5, 24'd6};
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    step(1);
    reset_n = 1'b0;
    enable = 1'b0;
    mstate = 0;
    mw = 0;
    mr = 0;
    #1;
    check("midrun_rst_data", out_data, 48'd0);
    check("midrun_rst_valid", 48'(out_valid), 48'd0);
    check("midrun_rst_overrun", 48'(overrun), 48'd0);
    step(4);
    reset_n = 1'b1;
    step(2);
    do_tick(24'h000ABC, 24'hABC000);
    set_en(1'b1);
    repeat (4) do_tick(24'd7, 24'd7);
    step(10);
    nvec++;
    assert (exp_q.size() == 0) else begin
      nerr++;
      $error("FAIL drain: observed %0d outputs still pending, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
